box_frame_sequencer: RTL



---
 rtl/box_frame_sequencer_if.sv | 42 ++++
 rtl/box_frame_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/box_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// box_frame_sequencer_if
//
// Purpose: groups the signals between the game-logic block, the box frame
// sequencer and the VGA adapter write port into one bundle.
//
// Signals:
//   frame_tick  game logic -> sequencer  one-cycle redraw request
//   box_y[6:0]  game logic -> sequencer  box centre row, sampled on a tick
//   plot        sequencer  -> VGA        write enable
//   x[7:0]      sequencer  -> VGA        pixel column
//   y[6:0]      sequencer  -> VGA        pixel row
//   colour[2:0] sequencer  -> VGA        pixel colour
//   busy        sequencer  -> monitor    high while a frame update runs
//   done        sequencer  -> monitor    one-cycle pulse at end of update
//   overrun     sequencer  -> monitor    sticky "tick arrived while busy"
//
// Modports:
//   slave  : the sequencer's view (consumes the tick, drives the pixel bus)
//   master : the environment's view (drives the tick, observes the outputs)
// -----------------------------------------------------------------------------
interface box_frame_sequencer_if;
  logic       frame_tick;
  logic [6:0] box_y;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       done;
  logic       overrun;

  modport slave (
    input  frame_tick, box_y,
    output plot, x, y, colour, busy, done, overrun
  );

  modport master (
    output frame_tick, box_y,
    input  plot, x, y, colour, busy, done, overrun
  );
endinterface

// File: rtl/box_frame_sequencer.sv
// -----------------------------------------------------------------------------
// box_frame_sequencer
//
// Purpose: per-frame controller owning the VGA adapter write port for the
// 3x3 player box. On an accepted frame tick it erases the box at its previous
// row in the background colour (skipped on the first frame or when the box
// has not moved), then draws it at the newly sampled row in the box colour,
// emitting one pixel per clock.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset; aborts any pass in progress
//   bus    box_frame_sequencer_if.slave (frame_tick, box_y in;
//          plot, x, y, colour, busy, done, overrun out)
//
// Parameters:
//   BOX_X       centre column; box spans BOX_X-1 .. BOX_X+1
//   Y_MAX       last visible row; rows outside 0..Y_MAX are not plotted
//   BOX_COLOUR  colour of the draw pass
//   BG_COLOUR   colour of the erase pass
// -----------------------------------------------------------------------------
module box_frame_sequencer #(
  parameter int         BOX_X      = 4,
  parameter int         Y_MAX      = 119,
  parameter logic [2:0] BOX_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  box_frame_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic signed [7:0] Y_MAX_S   = 8'(Y_MAX);
  localparam logic [7:0]        X_FIRST   = 8'(BOX_X - 1);

  state_t     state_q, state_d;
  logic [1:0] dx_q, dx_d;
  logic [1:0] dy_q, dy_d;
  logic [6:0] cur_y_q, cur_y_d;
  logic [6:0] prev_y_q, prev_y_d;
  logic       prev_valid_q, prev_valid_d;
  logic       overrun_q, overrun_d;

  // Last pixel coordinates/colour, so the bus holds its value outside a pass.
  logic [7:0] x_hold_q, x_hold_d;
  logic [6:0] y_hold_q, y_hold_d;
  logic [2:0] colour_hold_q, colour_hold_d;

  // Pixel decode: purely from state and counter registers.
  logic              in_pass;
  logic [6:0]        base_y;
  logic signed [7:0] row_s;
  logic              row_clipped;
  logic [7:0]        pix_x;
  logic [2:0]        pix_colour;

  assign in_pass    = (state_q == ERASE) || (state_q == DRAW);
  assign base_y     = (state_q == ERASE) ? prev_y_q : cur_y_q;
  assign pix_colour = (state_q == ERASE) ? BG_COLOUR : BOX_COLOUR;
  assign pix_x      = X_FIRST + {6'd0, dx_q};

  // Row as 8-bit signed so that centre row 0 yields -1 for the top line and
  // centre 127 wraps to a negative value rather than aliasing a visible row.
  assign row_s       = $signed({1'b0, base_y}) + $signed({6'd0, dy_q}) - 8'sd1;
  assign row_clipped = row_s[7] || (row_s > Y_MAX_S);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dx_q          <= 2'd0;
      dy_q          <= 2'd0;
      cur_y_q       <= 7'd0;
      prev_y_q      <= 7'd0;
      prev_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      x_hold_q      <= 8'd0;
      y_hold_q      <= 7'd0;
      colour_hold_q <= BG_COLOUR;
    end else begin
      state_q       <= state_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      cur_y_q       <= cur_y_d;
      prev_y_q      <= prev_y_d;
      prev_valid_q  <= prev_valid_d;
      overrun_q     <= overrun_d;
      x_hold_q      <= x_hold_d;
      y_hold_q      <= y_hold_d;
      colour_hold_q <= colour_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    cur_y_d       = cur_y_q;
    prev_y_d      = prev_y_q;
    prev_valid_d  = prev_valid_q;
    overrun_d     = overrun_q;
    x_hold_d      = x_hold_q;
    y_hold_d      = y_hold_q;
    colour_hold_d = colour_hold_q;

    // Any tick outside IDLE is dropped but remembered.
    if (bus.frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // Capture every emitted pixel (plotted or clipped) for holding later.
    if (in_pass) begin
      x_hold_d      = pix_x;
      y_hold_d      = row_s[6:0];
      colour_hold_d = pix_colour;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          cur_y_d = bus.box_y;
          dx_d    = 2'd0;
          dy_d    = 2'd0;
          if (prev_valid_q && (bus.box_y != prev_y_q)) begin
            state_d = ERASE;
          end else begin
            state_d = DRAW;
          end
        end
      end

      ERASE, DRAW: begin
        // dy outer, dx inner, each 0..2.
        if (dx_q == 2'd2) begin
          dx_d = 2'd0;
          if (dy_q == 2'd2) begin
            dy_d    = 2'd0;
            state_d = (state_q == ERASE) ? DRAW : DONE;
          end else begin
            dy_d = dy_q + 2'd1;
          end
        end else begin
          dx_d = dx_q + 2'd1;
        end
      end

      DONE: begin
        prev_y_d     = cur_y_q;
        prev_valid_d = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.plot   = 1'b0;
    bus.x      = x_hold_q;
    bus.y      = y_hold_q;
    bus.colour = colour_hold_q;
    if (in_pass) begin
      bus.plot   = !row_clipped;
      bus.x      = pix_x;
      bus.y      = row_s[6:0];
      bus.colour = pix_colour;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.overrun = overrun_q;

endmodule
